ibex_rvfi_trace_buffer: RTL
===========================

Name: ibex_rvfi_trace_buffer

Overview:
- Downstream consumer of the core's RVFI retirement stream. Sits beside the tracer in the tracing wrapper or the lockstep top.
- Captures one compact record per retired instruction into a small FIFO. A debug/trace sink drains the FIFO over a valid/ready port.
- Counts records dropped on overflow and flags gaps in rvfi_order, so lost retirements are visible to software and verification.

Parameters:
- Depth, 8, number of FIFO entries; power of two, >= 2.
- DropCntW, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- enable_i  in  1  capture enable; when 0, rvfi_valid_i is ignored entirely (no push, no drop count, no order check)
- clear_i  in  1  single-cycle pulse; clears drop_cnt_o, overflow_o, order_err_o and re-arms the order tracker; does not flush the FIFO
- rvfi_valid_i  in  1  retirement strobe
- rvfi_order_i  in  64  retirement sequence number
- rvfi_insn_i  in  32  instruction word
- rvfi_trap_i  in  1  trap flag
- rvfi_intr_i  in  1  first instruction of a handler
- rvfi_mode_i  in  2  privilege mode
- rvfi_rd_addr_i  in  5  destination register
- rvfi_rd_wdata_i  in  32  destination write data
- rvfi_pc_rdata_i  in  32  PC of the retired instruction
- rvfi_mem_addr_i  in  32  memory address; used only with the optional feature
- rvfi_mem_rmask_i  in  4  memory read mask; used only with the optional feature
- rvfi_mem_wmask_i  in  4  memory write mask; used only with the optional feature
- trace_valid_o  out  1  FIFO not empty
- trace_ready_i  in  1  sink accepts the head record
- trace_rdata_o  out  RecW  head record
- level_o  out  $clog2(Depth)+1  current occupancy
- drop_cnt_o  out  DropCntW  records dropped on overflow; saturating
- overflow_o  out  1  sticky: at least one drop since reset/clear
- order_err_o  out  1  sticky: rvfi_order discontinuity detected

Behaviour:
- Record layout, MSB to LSB: {mode[1:0], intr, trap, rd_addr[4:0], rd_wdata[31:0], insn[31:0], pc[31:0]}. RecW = 105.
- Push condition: rvfi_valid_i & enable_i & (not full, or pop in the same cycle).
- Pop condition: trace_valid_o & trace_ready_i.
- Latency: a record pushed in cycle N is visible on trace_valid_o/trace_rdata_o in cycle N+1. There is no combinational path from rvfi_* to the trace_* outputs.
- trace_rdata_o is driven from storage at the read pointer and is stable while trace_valid_o=1 and trace_ready_i=0.
- Pointers are $clog2(Depth)+1 bits wide, with the MSB used as the wrap bit.
  - full = (address bits equal, wrap bits differ).
  - empty = (pointers equal).
  - Pointers wrap naturally.
- Full with simultaneous push and pop: both are performed; level_o is unchanged.
- Empty with push and no pop: level_o becomes 1. There is no bypass to the output in the same cycle.
- Full with push and no pop: the record is dropped.
  - drop_cnt_o increments and saturates at all-ones.
  - overflow_o is set.
  - FIFO contents are unchanged.
- Order tracker FSM:
  - States: UNARMED, ARMED.
  - UNARMED: on a capture-enabled rvfi_valid_i, latch exp_order = rvfi_order_i + 1 and go to ARMED. No check is made.
  - ARMED: on each capture-enabled rvfi_valid_i, if rvfi_order_i != exp_order, set order_err_o. In both cases, exp_order <= rvfi_order_i + 1.
  - The check applies to dropped records as well as pushed ones.
  - clear_i returns the FSM to UNARMED.
  - If clear_i and rvfi_valid_i occur in the same cycle, clear takes priority for the sticky flags and the counter. The record is still pushed if space exists, and it arms the tracker (UNARMED to ARMED with no check).
  - exp_order arithmetic is 64-bit modulo.
- Reset (rst_i=1 at a clock edge, including mid-operation):
  - Pointers go to 0 and the FIFO is emptied; in-flight records are discarded.
  - trace_valid_o=0, level_o=0, drop_cnt_o=0, overflow_o=0, order_err_o=0, FSM=UNARMED.
  - trace_rdata_o is don't-care while empty; the storage array is not reset.

Optional Feature:
- Macro: IBEX_RVFI_TRACE_MEM_EN.
- Defined: the record is extended at the MSB end with {mem_wmask[3:0], mem_rmask[3:0], mem_addr[31:0]}, giving RecW = 145. The rvfi_mem_* inputs are captured alongside the other fields.
- Not defined: RecW = 105; rvfi_mem_* ports remain present but are unused.

Test Plan:
- Reset, then push pc=0x100, insn=0x00500093, rd=1, rd_wdata=5, order=0 -> next cycle trace_valid_o=1, trace_rdata_o[31:0]=0x100, level_o=1; pop -> level_o=0, trace_valid_o=0.
- trace_ready_i=0, push 10 records (orders 0..9) into Depth=8 -> level_o=8, drop_cnt_o=2, overflow_o=1; drain -> orders 0..7 appear in order, pc fields intact.
- FIFO full with simultaneous push and pop for 5 cycles -> level_o stays 8, drop_cnt_o unchanged, output sequence continuous.
- Orders 0, 1, 3 -> order_err_o=1 at the cycle after order 3; clear_i pulse -> order_err_o=0; then orders 7, 8 -> no error (re-armed on 7).
- Drop counter saturation with DropCntW=4: 20 overflow pushes -> drop_cnt_o=15.
- rst_i asserted with level_o=5 mid-drain -> next cycle level_o=0, trace_valid_o=0, flags 0; with IBEX_RVFI_TRACE_MEM_EN defined, a push with mem_addr=0x2000, wmask=0xF -> trace_rdata_o[144:105]={4'hF, 4'h0, 32'h2000}.

Source files
------------

// File: rtl/ibex_rvfi_trace_buffer_if.sv
//------------------------------------------------------------------------------
// ibex_rvfi_trace_buffer_if
// RVFI retirement inputs and trace drain port of the RVFI trace buffer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ibex_rvfi_trace_buffer_if #(
`ifdef IBEX_RVFI_TRACE_MEM_EN
  parameter int unsigned RecW = 145
`else
  parameter int unsigned RecW = 105
`endif
);
  logic            rvfi_valid_i;
  logic [63:0]     rvfi_order_i;
  logic [31:0]     rvfi_insn_i;
  logic            rvfi_trap_i;
  logic            rvfi_intr_i;
  logic [1:0]      rvfi_mode_i;
  logic [4:0]      rvfi_rd_addr_i;
  logic [31:0]     rvfi_rd_wdata_i;
  logic [31:0]     rvfi_pc_rdata_i;
  logic [31:0]     rvfi_mem_addr_i;
  logic [3:0]      rvfi_mem_rmask_i;
  logic [3:0]      rvfi_mem_wmask_i;
  logic            trace_valid_o;
  logic            trace_ready_i;
  logic [RecW-1:0] trace_rdata_o;

  // Buffer side
  modport slave (
    input  rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_intr_i,
           rvfi_mode_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_pc_rdata_i,
           rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i, trace_ready_i,
    output trace_valid_o, trace_rdata_o
  );

  // Core/sink side
  modport master (
    output rvfi_valid_i, rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_intr_i,
           rvfi_mode_i, rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_pc_rdata_i,
           rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i, trace_ready_i,
    input  trace_valid_o, trace_rdata_o
  );
endinterface

`default_nettype wire

// File: rtl/ibex_rvfi_trace_buffer.sv
//------------------------------------------------------------------------------
// ibex_rvfi_trace_buffer
// Captures one record per RVFI retirement into a FIFO drained over valid/ready,
// counting overflow drops and flagging rvfi_order gaps.
// Optional macro IBEX_RVFI_TRACE_MEM_EN adds {wmask, rmask, mem_addr} at the MSB.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth    = 8,
  parameter int unsigned DropCntW = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  ibex_rvfi_trace_buffer_if.slave   bus,
  output logic [$clog2(Depth):0]    level_o,
  output logic [DropCntW-1:0]       drop_cnt_o,
  output logic                      overflow_o,
  output logic                      order_err_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;
`ifdef IBEX_RVFI_TRACE_MEM_EN
  localparam int unsigned RecW = 145;
`else
  localparam int unsigned RecW = 105;
`endif

  typedef enum logic [0:0] {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } order_state_e;

  logic [RecW-1:0]     mem_q [Depth];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [DropCntW-1:0] drop_cnt_q;
  logic                overflow_q;
  logic                order_err_q, order_err_d;
  order_state_e        state_q, state_d;
  logic [63:0]         exp_order_q, exp_order_d;

  logic            capture, full, empty, push, pop, drop;
  logic [RecW-1:0] rec;

`ifdef IBEX_RVFI_TRACE_MEM_EN
  assign rec = {bus.rvfi_mem_wmask_i, bus.rvfi_mem_rmask_i, bus.rvfi_mem_addr_i,
                bus.rvfi_mode_i, bus.rvfi_intr_i, bus.rvfi_trap_i, bus.rvfi_rd_addr_i,
                bus.rvfi_rd_wdata_i, bus.rvfi_insn_i, bus.rvfi_pc_rdata_i};
`else
  assign rec = {bus.rvfi_mode_i, bus.rvfi_intr_i, bus.rvfi_trap_i, bus.rvfi_rd_addr_i,
                bus.rvfi_rd_wdata_i, bus.rvfi_insn_i, bus.rvfi_pc_rdata_i};

  logic unused_mem;
  assign unused_mem = ^{bus.rvfi_mem_addr_i, bus.rvfi_mem_rmask_i, bus.rvfi_mem_wmask_i};
`endif

  assign capture = bus.rvfi_valid_i & enable_i;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) & (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop     = ~empty & bus.trace_ready_i;
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  // Storage is intentionally not reset; contents are only observed when non-empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != {DropCntW{1'b1}}) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  // A record arriving with clear_i still arms the tracker, without a check.
  always_comb begin
    state_d     = state_q;
    exp_order_d = exp_order_q;
    order_err_d = order_err_q;
    if (clear_i) begin
      state_d     = UNARMED;
      order_err_d = 1'b0;
    end
    if (capture) begin
      if (state_q == ARMED && !clear_i && bus.rvfi_order_i != exp_order_q) begin
        order_err_d = 1'b1;
      end
      exp_order_d = bus.rvfi_order_i + 64'd1;
      state_d     = ARMED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= UNARMED;
      exp_order_q <= '0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_order_q <= exp_order_d;
      order_err_q <= order_err_d;
    end
  end

  assign bus.trace_valid_o = ~empty;
  assign bus.trace_rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o           = wr_ptr_q - rd_ptr_q;
  assign drop_cnt_o        = drop_cnt_q;
  assign overflow_o        = overflow_q;
  assign order_err_o       = order_err_q;

endmodule

`default_nettype wire
